// File: rtl/clint_mt.sv
// Core-local interruptor: shared 64-bit mtime, per-hart mtimecmp/msip,
// rt_clk tick synchroniser with runtime prescaler and timer enable.
module clint_mt #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int N_CORES     = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rt_clk,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    output logic [N_CORES-1:0]  mtip,
    output logic [N_CORES-1:0]  msip
);

    localparam int NL = DATA_W / 32;

    localparam logic [13:0] W_CMP   = 14'h1000;
    localparam logic [13:0] W_CTRL  = 14'h2FFC;
    localparam logic [13:0] W_MT_LO = 14'h2FFE;
    localparam logic [13:0] W_MT_HI = 14'h2FFF;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rt_prev;
    logic                   rt_edge;
    logic                   tick;

    logic                   en, en_n;
    logic [7:0]             presc, presc_n;
    logic [7:0]             cnt, cnt_n;
    logic                   ctrl_wr;

    logic [63:0]            mtime, mtime_n;
    logic [63:0]            mtime_w;
    logic                   mtime_wr;
    logic [63:0]            shadow, shadow_n;

    logic [63:0]            mtimecmp   [N_CORES];
    logic [63:0]            mtimecmp_n [N_CORES];
    logic [N_CORES-1:0]     msip_q, msip_n;
    logic [N_CORES-1:0]     mtip_q;

    logic                   ready_q;
    logic [DATA_W-1:0]      rdata_q, rdata_n;

    logic                   is_wr;
    logic                   is_rd;
    logic                   unused_addr;

    assign unused_addr = ^address;

    assign is_wr   = valid & (|wstrb);
    assign is_rd   = valid & ~(|wstrb);
    assign rt_edge = sync_q[SYNC_STAGES-1] & ~rt_prev;
    assign tick    = rt_edge & en & (cnt == presc);

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] d,
        input logic [3:0]  s
    );
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    always_comb begin
        logic [13:0] wa;
        logic [3:0]  ws;
        logic [31:0] wd;
        logic [31:0] rw;

        en_n     = en;
        presc_n  = presc;
        ctrl_wr  = 1'b0;
        mtime_wr = 1'b0;
        mtime_w  = mtime;
        shadow_n = shadow;
        msip_n   = msip_q;
        rdata_n  = '0;
        for (int h = 0; h < N_CORES; h++) mtimecmp_n[h] = mtimecmp[h];

        // Each 32-bit lane of the bus is decoded as its own word address
        for (int l = 0; l < NL; l++) begin
            wa = (address[15:2] & ~14'(NL - 1)) | 14'(l);
            ws = wstrb[4*l +: 4];
            wd = wdata[32*l +: 32];
            rw = '0;

            for (int h = 0; h < N_CORES; h++) begin
                if (wa == 14'(h)) begin
                    rw = {31'b0, msip_q[h]};
                    if (is_wr && ws[0]) msip_n[h] = wd[0];
                end
                if (wa == W_CMP + 14'(2 * h)) begin
                    rw = mtimecmp[h][31:0];
                    if (is_wr) begin
                        mtimecmp_n[h][31:0] = merge(mtimecmp[h][31:0], wd, ws);
                    end
                end
                if (wa == W_CMP + 14'(2 * h + 1)) begin
                    rw = mtimecmp[h][63:32];
                    if (is_wr) begin
                        mtimecmp_n[h][63:32] = merge(mtimecmp[h][63:32], wd, ws);
                    end
                end
            end

            if (wa == W_CTRL) begin
                rw = {16'b0, presc, 7'b0, en};
                if (is_wr && (|ws)) begin
                    ctrl_wr = 1'b1;
                    if (ws[0]) en_n    = wd[0];
                    if (ws[1]) presc_n = wd[15:8];
                end
            end

            if (wa == W_MT_LO) begin
                rw = mtime[31:0];
                if (is_rd) shadow_n = {32'b0, mtime[63:32]};
                if (is_wr && (|ws)) begin
                    mtime_wr      = 1'b1;
                    mtime_w[31:0] = merge(mtime[31:0], wd, ws);
                end
            end

            if (wa == W_MT_HI) begin
                rw = (NL == 1) ? shadow[31:0] : mtime[63:32];
                if (is_wr && (|ws)) begin
                    mtime_wr       = 1'b1;
                    mtime_w[63:32] = merge(mtime[63:32], wd, ws);
                end
            end

            if (is_rd) rdata_n[32*l +: 32] = rw;
        end

        if (ctrl_wr) begin
            cnt_n = '0;
        end else if (rt_edge && en) begin
            cnt_n = tick ? 8'd0 : cnt + 8'd1;
        end else begin
            cnt_n = cnt;
        end

        // A bus write to mtime beats a coincident tick
        mtime_n = mtime_wr ? mtime_w : mtime + 64'(tick);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            rt_prev <= 1'b0;
            en      <= 1'b1;
            presc   <= '0;
            cnt     <= '0;
            mtime   <= '0;
            shadow  <= '0;
            msip_q  <= '0;
            mtip_q  <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            for (int h = 0; h < N_CORES; h++) mtimecmp[h] <= '1;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rt_clk};
            rt_prev <= sync_q[SYNC_STAGES-1];
            en      <= en_n;
            presc   <= presc_n;
            cnt     <= cnt_n;
            mtime   <= mtime_n;
            shadow  <= shadow_n;
            msip_q  <= msip_n;
            ready_q <= valid;
            if (valid) rdata_q <= rdata_n;
            for (int h = 0; h < N_CORES; h++) begin
                mtimecmp[h] <= mtimecmp_n[h];
                mtip_q[h]   <= (mtime >= mtimecmp[h]);
            end
        end
    end

    assign ready = ready_q;
    assign rdata = rdata_q;
    assign mtip  = mtip_q;
    assign msip  = msip_q;

endmodule

// File: tb/tb_clint_mt.sv
// Directed plus randomized checks of clint_mt against a behavioural model
// (32-bit bus, four harts).
module tb_clint_mt;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rt_clk = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] address = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic [31:0] rdata;
    logic        ready;
    logic [3:0]  mtip;
    logic [3:0]  msip;

    int errors = 0;
    int checks = 0;

    logic [63:0] cmp_m [4];
    logic [3:0]  msip_m;
    int          edges;
    int          presc_m;

    clint_mt #(
        .ADDR_W(16),
        .DATA_W(32),
        .N_CORES(4),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rt_clk(rt_clk),
        .valid(valid),
        .address(address),
        .wdata(wdata),
        .wstrb(wstrb),
        .rdata(rdata),
        .ready(ready),
        .mtip(mtip),
        .msip(msip)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] r);
        @(negedge clk);
        chk("ready_idle", {63'b0, ready}, 64'd0);
        valid   = 1'b1;
        address = a;
        wdata   = d;
        wstrb   = s;
        @(negedge clk);
        chk("ready_pulse", {63'b0, ready}, 64'd1);
        r     = rdata;
        valid = 1'b0;
        wstrb = '0;
    endtask

    task automatic rd64(input logic [15:0] a, output logic [63:0] v);
        logic [31:0] lo, hi;
        bus(a, '0, 4'h0, lo);
        bus(a + 16'd4, '0, 4'h0, hi);
        v = {hi, lo};
    endtask

    task automatic pulse();
        int hi, lo;
        hi = $urandom_range(2, 5);
        lo = $urandom_range(4, 7);
        @(negedge clk);
        rt_clk = 1'b1;
        repeat (hi) @(negedge clk);
        rt_clk = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    function automatic logic [31:0] bmerge(input logic [31:0] old,
                                           input logic [31:0] d,
                                           input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    initial begin
        logic [31:0] r, r0;
        logic [63:0] v, mt;
        logic [3:0]  exp_mtip;

        repeat (3) @(negedge clk);
        chk("rst_ready", {63'b0, ready}, 64'd0);
        chk("rst_rdata", {32'b0, rdata}, 64'd0);
        chk("rst_mtip", {60'b0, mtip}, 64'd0);
        chk("rst_msip", {60'b0, msip}, 64'd0);
        reset = 1'b0;

        rd64(16'h4000, v);
        chk("cmp0_rst", v, 64'hFFFF_FFFF_FFFF_FFFF);

        bus(16'h0008, 32'h1, 4'hF, r);
        chk("msip2_set", {60'b0, msip}, 64'h4);
        bus(16'h0008, '0, 4'h0, r);
        chk("msip2_rd", {32'b0, r}, 64'h1);
        bus(16'h0014, 32'h1, 4'hF, r);
        chk("msip5_ign", {60'b0, msip}, 64'h4);
        bus(16'h0014, '0, 4'h0, r);
        chk("msip5_rd", {32'b0, r}, 64'h0);

        bus(16'hBFF0, 32'h0000_0301, 4'hF, r);
        repeat (8) pulse();
        rd64(16'hBFF8, v);
        chk("presc3_8edges", v, 64'd2);
        bus(16'hBFF0, 32'h0000_0300, 4'hF, r);
        repeat (4) pulse();
        rd64(16'hBFF8, v);
        chk("en0_hold", v, 64'd2);

        @(negedge clk);
        valid   = 1'b1;
        address = 16'hBFF0;
        @(negedge clk);
        chk("b2b_ready0", {63'b0, ready}, 64'd1);
        chk("b2b_ctrl", {32'b0, rdata}, 64'h300);
        address = 16'h0008;
        @(negedge clk);
        chk("b2b_ready1", {63'b0, ready}, 64'd1);
        chk("b2b_msip", {32'b0, rdata}, 64'h1);
        valid = 1'b0;

        bus(16'hBFF8, 32'hFFFF_FFFE, 4'hF, r);
        bus(16'hBFFC, 32'hFFFF_FFFF, 4'hF, r);
        bus(16'hBFF0, 32'h0000_0001, 4'hF, r);
        repeat (3) pulse();
        rd64(16'hBFF8, v);
        chk("wrap", v, 64'd1);

        bus(16'h4000, 32'd5, 4'hF, r);
        bus(16'h4004, 32'd0, 4'hF, r);
        @(negedge clk);
        chk("mtip_low", {63'b0, mtip[0]}, 64'd0);
        repeat (3) pulse();
        chk("mtip_at4", {63'b0, mtip[0]}, 64'd0);
        @(negedge clk);
        rt_clk = 1'b1;
        repeat (3) @(negedge clk);
        chk("mtip_pre", {63'b0, mtip[0]}, 64'd0);
        @(negedge clk);
        chk("mtip_rise", {63'b0, mtip[0]}, 64'd1);
        rt_clk = 1'b0;
        repeat (4) @(negedge clk);

        bus(16'hBFFC, 32'h0, 4'hF, r);
        bus(16'hBFF8, 32'hFFFF_FFFF, 4'hF, r);
        bus(16'hBFF8, '0, 4'h0, r);
        chk("shadow_lo", {32'b0, r}, 64'hFFFF_FFFF);
        pulse();
        bus(16'hBFFC, '0, 4'h0, r);
        chk("shadow_hi", {32'b0, r}, 64'h0);
        rd64(16'hBFF8, v);
        chk("post_tick", v, 64'h1_0000_0000);

        bus(16'h4008, 32'h0000_AB00, 4'b0010, r);
        bus(16'h4008, '0, 4'h0, r);
        chk("byte_wr", {32'b0, r}, 64'hFFFF_ABFF);

        @(negedge clk);
        rt_clk = 1'b1;
        @(negedge clk);
        bus(16'hBFF8, 32'h0000_1234, 4'hF, r);
        rt_clk = 1'b0;
        repeat (6) @(negedge clk);
        rd64(16'hBFF8, v);
        chk("wr_beats_tick", v, 64'h1_0000_1234);

        @(negedge clk);
        valid   = 1'b1;
        address = 16'hBFF0;
        reset   = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        chk("rst_drop_ready", {63'b0, ready}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("rst2_msip", {60'b0, msip}, 64'd0);

        presc_m = $urandom_range(0, 2);
        edges   = 0;
        msip_m  = '0;
        for (int h = 0; h < 4; h++) cmp_m[h] = '1;
        bus(16'hBFF0, {16'b0, 8'(presc_m), 8'h01}, 4'hF, r);
        rd64(16'hBFF8, v);
        chk("rst2_mtime", v, 64'd0);

        for (int it = 0; it < 60; it++) begin
            int op, h, half;
            logic [3:0] s;
            op = $urandom_range(0, 4);
            h  = $urandom_range(0, 5);
            mt = 64'(edges / (presc_m + 1));
            case (op)
                0: begin
                    h = $urandom_range(0, 7);
                    r0 = $urandom;
                    bus(16'(4 * h), r0, 4'hF, r);
                    if (h < 4) msip_m[h] = r0[0];
                end
                1: begin
                    half = $urandom_range(0, 1);
                    s    = 4'($urandom_range(1, 15));
                    r0   = $urandom_range(0, 1) ? 32'($urandom_range(0, 12)) : $urandom;
                    bus(16'h4000 + 16'(8 * h + 4 * half), r0, s, r);
                    if (h < 4) cmp_m[h][32*half +: 32] = bmerge(cmp_m[h][32*half +: 32], r0, s);
                end
                2: begin
                    half = $urandom_range(0, 1);
                    bus(16'h4000 + 16'(8 * h + 4 * half), '0, 4'h0, r);
                    chk("rnd_cmp_rd", {32'b0, r}, (h < 4) ? {32'b0, cmp_m[h][32*half +: 32]} : 64'd0);
                    bus(16'(4 * h), '0, 4'h0, r);
                    chk("rnd_msip_rd", {32'b0, r}, (h < 4) ? {63'b0, msip_m[h]} : 64'd0);
                end
                3: begin
                    pulse();
                    edges++;
                end
                default: begin
                    rd64(16'hBFF8, v);
                    chk("rnd_mtime", v, mt);
                end
            endcase
            @(negedge clk);
            mt = 64'(edges / (presc_m + 1));
            for (int k = 0; k < 4; k++) exp_mtip[k] = (mt >= cmp_m[k]);
            chk("rnd_msip", {60'b0, msip}, {60'b0, msip_m});
            chk("rnd_mtip", {60'b0, mtip}, {60'b0, exp_mtip});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
